// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences R/I/load/store/branch instructions and
// drives per-state datapath strobes, with memory handshake timeout and trap states.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALUOP_W     = 2,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  input  logic               branch_cond,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               bus_error,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_ALU = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_TRAP   = 4'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [3:0]       state, next_state;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             cause_bus, cause_bus_next;
  logic             mem_state, timeout;

  assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // The last permitted wait cycle traps unless mem_ready arrives in that same cycle.
  assign timeout   = mem_state && !mem_ready && (wait_cnt == CNT_LIMIT);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    next_state     = S_FETCH;
    cause_bus_next = cause_bus;
    case (state)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          next_state = (state == S_FETCH)  ? S_DECODE :
                       (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (timeout) begin
          next_state     = S_TRAP;
          cause_bus_next = 1'b1;
        end else begin
          next_state = state;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               next_state = S_EXEC_R;
          OP_I:               next_state = S_EXEC_I;
          OP_LOAD, OP_STORE:  next_state = S_ADDR;
          OP_BRANCH:          next_state = S_BRANCH;
          default: begin
            next_state     = S_TRAP;
            cause_bus_next = 1'b0;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: next_state = S_WB_ALU;
      S_ADDR:             next_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      default:            next_state = S_FETCH;
    endcase

    wait_cnt_next = '0;
    if (mem_state && !mem_ready && next_state == state)
      wait_cnt_next = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      cause_bus <= 1'b0;
    end else begin
      state     <= next_state;
      wait_cnt  <= wait_cnt_next;
      cause_bus <= cause_bus_next;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = '0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_error  = 1'b0;
    state_dbg  = '0;
    // Reset forces every output low, abandoning any in-flight instruction.
    if (!rst) begin
      state_dbg = STATE_W'(state);
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b10;
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_W'(2);
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = ALUOP_W'(2);
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEM_WR: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_WB_ALU: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALUOP_W'(1);
          pc_write   = branch_cond;
          instr_done = 1'b1;
        end
        S_TRAP: begin
          illegal_op = !cause_bus;
          bus_error  = cause_bus;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver queues the expected state and
// strobe word for each cycle, and a negedge monitor pops and compares it.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready, branch_cond;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, mem_to_reg;
  logic       alu_src_a, instr_done, illegal_op, bus_error;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state_dbg;

  multicycle_control_fsm #(.MEM_TIMEOUT(16), .ALUOP_W(2), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .branch_cond(branch_cond), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
    .bus_error(bus_error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Output word: mem_req mem_we i_or_d ir_write pc_write reg_write mem_to_reg a b[1:0] op[1:0] done ill bus
  localparam logic [14:0] ZERO   = 15'b0_0_0_0_0_0_0_0_00_00_0_0_0;
  localparam logic [14:0] F_WAIT = 15'b1_0_0_0_0_0_0_0_01_00_0_0_0;
  localparam logic [14:0] F_RDY  = 15'b1_0_0_1_1_0_0_0_01_00_0_0_0;
  localparam logic [14:0] DEC    = 15'b0_0_0_0_0_0_0_0_10_00_0_0_0;
  localparam logic [14:0] EXR    = 15'b0_0_0_0_0_0_0_1_00_10_0_0_0;
  localparam logic [14:0] EXI    = 15'b0_0_0_0_0_0_0_1_10_10_0_0_0;
  localparam logic [14:0] ADR    = 15'b0_0_0_0_0_0_0_1_10_00_0_0_0;
  localparam logic [14:0] MRD    = 15'b1_0_1_0_0_0_0_0_00_00_0_0_0;
  localparam logic [14:0] MWR_W  = 15'b1_1_1_0_0_0_0_0_00_00_0_0_0;
  localparam logic [14:0] MWR_R  = 15'b1_1_1_0_0_0_0_0_00_00_1_0_0;
  localparam logic [14:0] WBA    = 15'b0_0_0_0_0_1_0_0_00_00_1_0_0;
  localparam logic [14:0] WBM    = 15'b0_0_0_0_0_1_1_0_00_00_1_0_0;
  localparam logic [14:0] BR1    = 15'b0_0_0_0_1_0_0_1_00_01_1_0_0;
  localparam logic [14:0] BR0    = 15'b0_0_0_0_0_0_0_1_00_01_1_0_0;
  localparam logic [14:0] TRI    = 15'b0_0_0_0_0_0_0_0_00_00_0_1_0;
  localparam logic [14:0] TRB    = 15'b0_0_0_0_0_0_0_0_00_00_0_0_1;

  localparam logic [6:0] OP_R  = 7'b0110011, OP_I  = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [14:0] outs;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [14:0] act;
  assign act = {mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, instr_done, illegal_op, bus_error};

  task automatic check(input string name, input logic [3:0] st_got, input logic [14:0] o_got,
                       input logic [3:0] st_exp, input logic [14:0] o_exp);
    n_cmp++;
    if (st_got !== st_exp || o_got !== o_exp) begin
      n_bad++;
      $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
               name, st_got, o_got, st_exp, o_exp);
    end
  endtask

  // Drive one cycle of inputs and queue the response expected during that cycle.
  task automatic step(input string name, input logic r, input logic [6:0] op,
                      input logic rdy, input logic bc, input logic [3:0] st,
                      input logic [14:0] outs);
    exp_t e;
    rst = r; opcode = op; mem_ready = rdy; branch_cond = bc;
    e.name = name; e.st = st; e.outs = outs;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, state_dbg, act, e.st, e.outs);
      end
    end
  end

  initial begin : driver
    rst = 1'b1; opcode = '0; mem_ready = 1'b0; branch_cond = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset, then R-type and I-type with zero-wait memory
    for (int i = 0; i < 3; i++) step("reset", 1, OP_R, 1, 0, 4'd0, ZERO);
    step("r_fetch",  0, OP_R, 1, 0, 4'd0, F_RDY);
    step("r_decode", 0, OP_R, 1, 0, 4'd1, DEC);
    step("r_exec",   0, OP_R, 1, 0, 4'd2, EXR);
    step("r_wb",     0, OP_R, 1, 0, 4'd7, WBA);
    step("i_fetch",  0, OP_I, 1, 0, 4'd0, F_RDY);
    step("i_decode", 0, OP_I, 1, 0, 4'd1, DEC);
    step("i_exec",   0, OP_I, 1, 0, 4'd3, EXI);
    step("i_wb",     0, OP_I, 1, 0, 4'd7, WBA);

    // 2: load with three wait cycles in MEM_RD
    step("ld_fetch",  0, OP_LD, 1, 0, 4'd0, F_RDY);
    step("ld_decode", 0, OP_LD, 1, 0, 4'd1, DEC);
    step("ld_addr",   0, OP_LD, 1, 0, 4'd4, ADR);
    for (int i = 0; i < 3; i++) step("ld_wait", 0, OP_LD, 0, 0, 4'd5, MRD);
    step("ld_memrd",  0, OP_LD, 1, 0, 4'd5, MRD);
    step("ld_wb",     0, OP_LD, 1, 0, 4'd8, WBM);

    // zero-wait store: four cycles
    step("st_fetch",  0, OP_ST, 1, 0, 4'd0, F_RDY);
    step("st_decode", 0, OP_ST, 1, 0, 4'd1, DEC);
    step("st_addr",   0, OP_ST, 1, 0, 4'd4, ADR);
    step("st_memwr",  0, OP_ST, 1, 0, 4'd6, MWR_R);

    // 3: branch taken, then not taken
    step("br1_fetch",  0, OP_BR, 1, 1, 4'd0, F_RDY);
    step("br1_decode", 0, OP_BR, 1, 1, 4'd1, DEC);
    step("br1_branch", 0, OP_BR, 1, 1, 4'd9, BR1);
    step("br0_fetch",  0, OP_BR, 1, 0, 4'd0, F_RDY);
    step("br0_decode", 0, OP_BR, 1, 0, 4'd1, DEC);
    step("br0_branch", 0, OP_BR, 1, 0, 4'd9, BR0);

    // 4: illegal opcode
    step("ill_fetch",  0, OP_BAD, 1, 0, 4'd0, F_RDY);
    step("ill_decode", 0, OP_BAD, 1, 0, 4'd1, DEC);
    step("ill_trap",   0, OP_BAD, 1, 0, 4'd10, TRI);

    // 5: fetch timeout after 16 waits, then ready on the 16th cycle
    for (int i = 0; i < 16; i++) step("to_wait", 0, OP_R, 0, 0, 4'd0, F_WAIT);
    step("to_trap", 0, OP_R, 0, 0, 4'd10, TRB);
    for (int i = 0; i < 15; i++) step("lim_wait", 0, OP_R, 0, 0, 4'd0, F_WAIT);
    step("lim_fetch",  0, OP_R, 1, 0, 4'd0, F_RDY);
    step("lim_decode", 0, OP_R, 1, 0, 4'd1, DEC);
    step("lim_exec",   0, OP_R, 1, 0, 4'd2, EXR);
    step("lim_wb",     0, OP_R, 1, 0, 4'd7, WBA);

    // 6: reset in MEM_WR mid-wait
    step("rs_fetch",  0, OP_ST, 1, 0, 4'd0, F_RDY);
    step("rs_decode", 0, OP_ST, 1, 0, 4'd1, DEC);
    step("rs_addr",   0, OP_ST, 1, 0, 4'd4, ADR);
    step("rs_wait",   0, OP_ST, 0, 0, 4'd6, MWR_W);
    step("rs_wait",   0, OP_ST, 0, 0, 4'd6, MWR_W);
    step("rs_reset",  1, OP_ST, 0, 0, 4'd0, ZERO);
    step("rs_after",  0, OP_ST, 0, 0, 4'd0, F_WAIT);
    step("rs_fetch2", 0, OP_R,  1, 0, 4'd0, F_RDY);
    step("rs_decode2",0, OP_R,  1, 0, 4'd1, DEC);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
